// File: rtl/nand_clk_pkg.sv
// nand_clk_pkg: shared FSM states and bring-up timing defaults for clock/reset supervisors
package nand_clk_pkg;
    typedef enum logic [2:0] {
        S_RST     = 3'd0,
        S_WAIT    = 3'd1,
        S_STABLE  = 3'd2,
        S_RELEASE = 3'd3,
        S_RUN     = 3'd4,
        S_FAIL    = 3'd5
    } state_t;
    localparam int DEF_RST_PULSE_CYC    = 16;
    localparam int DEF_LOCK_TIMEOUT_CYC = 50000;
    localparam int DEF_STABLE_CYC       = 64;
    localparam int DEF_MAX_RETRY        = 4;
    localparam int DEF_NUM_DOM          = 3;
    localparam int DEF_STAGGER_CYC      = 8;
    localparam int DEF_CNT_W            = 16;
endpackage

// File: rtl/nand_clk_rst_seq_sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous level signals
module sync_2ff #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/nand_clk_rst_seq.sv
// nand_clk_rst_seq: MMCM reset/lock supervisor with timeout retry and staggered domain reset release
module nand_clk_rst_seq
    import nand_clk_pkg::*;
#(
    parameter int RST_PULSE_CYC    = DEF_RST_PULSE_CYC,
    parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
    parameter int STABLE_CYC       = DEF_STABLE_CYC,
    parameter int MAX_RETRY        = DEF_MAX_RETRY,
    parameter int NUM_DOM          = DEF_NUM_DOM,
    parameter int STAGGER_CYC      = DEF_STAGGER_CYC,
    parameter int CNT_W            = DEF_CNT_W
) (
    input  logic               clk_in,
    input  logic               reset,
    input  logic               mmcm_locked,
    input  logic               soft_restart,
    output logic               mmcm_reset,
    output logic [NUM_DOM-1:0] dom_resetn,
    output logic               sys_ready,
    output logic               fail,
    output logic [3:0]         retry_cnt,
    output logic [7:0]         lock_loss_cnt,
    output logic [2:0]         state
);
    localparam int IDX_W = $clog2(NUM_DOM + 1);
    state_t           st;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic             locked_s;
    logic             rel_now;
    sync_2ff #(.W(1)) u_lock_sync (
        .clk (clk_in),
        .rst (reset),
        .d   (mmcm_locked),
        .q   (locked_s)
    );
    assign state   = st;
    assign rel_now = cnt == CNT_W'(idx) * CNT_W'(STAGGER_CYC);
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            st            <= S_RST;
            cnt           <= '0;
            idx           <= '0;
            mmcm_reset    <= 1'b1;
            dom_resetn    <= '0;
            sys_ready     <= 1'b0;
            fail          <= 1'b0;
            retry_cnt     <= '0;
            lock_loss_cnt <= '0;
        end else if (soft_restart) begin
            st         <= S_RST;
            cnt        <= '0;
            idx        <= '0;
            mmcm_reset <= 1'b1;
            dom_resetn <= '0;
            sys_ready  <= 1'b0;
            fail       <= 1'b0;
            retry_cnt  <= '0;
        end else begin
            cnt <= cnt + 1'b1;
            case (st)
                S_RST: if (cnt == CNT_W'(RST_PULSE_CYC - 1)) begin
                    st         <= S_WAIT;
                    cnt        <= '0;
                    mmcm_reset <= 1'b0;
                end
                S_WAIT: if (locked_s) begin
                    st  <= S_STABLE;
                    cnt <= '0;
                end else if (cnt == CNT_W'(LOCK_TIMEOUT_CYC - 1)) begin
                    cnt        <= '0;
                    mmcm_reset <= 1'b1;
                    if (retry_cnt == 4'(MAX_RETRY)) begin
                        st   <= S_FAIL;
                        fail <= 1'b1;
                    end else begin
                        st        <= S_RST;
                        retry_cnt <= retry_cnt + 1'b1;
                    end
                end
                S_STABLE: if (!locked_s) begin
                    st  <= S_WAIT;
                    cnt <= '0;
                end else if (cnt == CNT_W'(STABLE_CYC - 1)) begin
                    st  <= S_RELEASE;
                    cnt <= '0;
                end
                // a lock drop while releasing is handled exactly like one in RUN
                S_RELEASE, S_RUN: if (!locked_s) begin
                    st            <= S_RST;
                    cnt           <= '0;
                    idx           <= '0;
                    mmcm_reset    <= 1'b1;
                    dom_resetn    <= '0;
                    sys_ready     <= 1'b0;
                    lock_loss_cnt <= (lock_loss_cnt == 8'hff) ? lock_loss_cnt : lock_loss_cnt + 1'b1;
                end else if (st == S_RUN) begin
                    cnt       <= '0;
                    retry_cnt <= '0;
                end else if (rel_now) begin
                    dom_resetn <= dom_resetn | (NUM_DOM'(1) << idx);
                    idx        <= idx + 1'b1;
                    if (idx == IDX_W'(NUM_DOM - 1)) begin
                        st        <= S_RUN;
                        cnt       <= '0;
                        sys_ready <= 1'b1;
                        retry_cnt <= '0;
                    end
                end
                S_FAIL: cnt <= '0;
                default: begin
                    st  <= S_RST;
                    cnt <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_nand_clk_rst_seq.sv
// tb_nand_clk_rst_seq: directed scenarios for the MMCM supervisor with a shortened lock timeout
module tb_nand_clk_rst_seq;
    localparam int TO = 300;
    logic       clk_in = 1'b0;
    logic       reset = 1'b1;
    logic       mmcm_locked = 1'b0;
    logic       soft_restart = 1'b0;
    logic       mmcm_reset;
    logic [2:0] dom_resetn;
    logic       sys_ready;
    logic       fail;
    logic [3:0] retry_cnt;
    logic [7:0] lock_loss_cnt;
    logic [2:0] state;
    int         total = 0;
    int         bad = 0;
    always #10 clk_in = ~clk_in;
    nand_clk_rst_seq #(.LOCK_TIMEOUT_CYC(TO)) dut (
        .clk_in        (clk_in),
        .reset         (reset),
        .mmcm_locked   (mmcm_locked),
        .soft_restart  (soft_restart),
        .mmcm_reset    (mmcm_reset),
        .dom_resetn    (dom_resetn),
        .sys_ready     (sys_ready),
        .fail          (fail),
        .retry_cnt     (retry_cnt),
        .lock_loss_cnt (lock_loss_cnt),
        .state         (state)
    );
    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk_in);
    endtask
    task automatic wait_state(input logic [2:0] s, input int lim, output int n);
        n = 0;
        while (state !== s && n < lim) begin
            tick();
            n++;
        end
    endtask
    task automatic pulse_soft;
        soft_restart = 1'b1;
        tick();
        soft_restart = 1'b0;
    endtask
    task automatic test_reset;
        int n;
        reset = 1'b1;
        tick(3);
        total++;
        if ({mmcm_reset, dom_resetn, sys_ready, fail, retry_cnt, lock_loss_cnt, state} !== {1'b1, 3'b000, 1'b0, 1'b0, 4'd0, 8'd0, 3'd0}) begin
            bad++;
            $display("FAIL reset_values got=%b exp=%b", {mmcm_reset, dom_resetn, sys_ready, fail, retry_cnt, lock_loss_cnt, state}, {1'b1, 3'b000, 1'b0, 1'b0, 4'd0, 8'd0, 3'd0});
        end
        reset = 1'b0;
        n = 0;
        while (mmcm_reset === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        total++;
        if (n !== 16) begin bad++; $display("FAIL rst_pulse_len got=%0d exp=16", n); end
        total++;
        if (state !== 3'd1) begin bad++; $display("FAIL wait_entry got=%0d exp=1", state); end
    endtask
    task automatic test_normal_lock;
        tick(100);
        mmcm_locked = 1'b1;
        tick(2);
        total++;
        if (state !== 3'd1) begin bad++; $display("FAIL lock_sync_lag got=%0d exp=1", state); end
        tick();
        total++;
        if (state !== 3'd2) begin bad++; $display("FAIL stable_entry got=%0d exp=2", state); end
        tick(63);
        total++;
        if (state !== 3'd2) begin bad++; $display("FAIL stable_hold got=%0d exp=2", state); end
        tick();
        total++;
        if (state !== 3'd3) begin bad++; $display("FAIL release_entry got=%0d exp=3", state); end
        tick();
        total++;
        if (dom_resetn !== 3'b001) begin bad++; $display("FAIL dom0_edge1 got=%b exp=001", dom_resetn); end
        tick(7);
        total++;
        if (dom_resetn !== 3'b001) begin bad++; $display("FAIL dom1_edge8 got=%b exp=001", dom_resetn); end
        tick();
        total++;
        if (dom_resetn !== 3'b011) begin bad++; $display("FAIL dom1_edge9 got=%b exp=011", dom_resetn); end
        tick(7);
        total++;
        if ({dom_resetn, state} !== {3'b011, 3'd3}) begin bad++; $display("FAIL dom2_edge16 got=%b exp=%b", {dom_resetn, state}, {3'b011, 3'd3}); end
        tick();
        total++;
        if ({dom_resetn, state, sys_ready, retry_cnt} !== {3'b111, 3'd4, 1'b1, 4'd0}) begin
            bad++;
            $display("FAIL run_entry got=%b exp=%b", {dom_resetn, state, sys_ready, retry_cnt}, {3'b111, 3'd4, 1'b1, 4'd0});
        end
    endtask
    task automatic test_lock_loss_run;
        int n;
        mmcm_locked = 1'b0;
        tick(2);
        total++;
        if ({sys_ready, dom_resetn} !== 4'b1111) begin bad++; $display("FAIL loss_sync_lag got=%b exp=1111", {sys_ready, dom_resetn}); end
        tick();
        total++;
        if ({dom_resetn, sys_ready, state, lock_loss_cnt} !== {3'b000, 1'b0, 3'd0, 8'd1}) begin
            bad++;
            $display("FAIL loss_react got=%b exp=%b", {dom_resetn, sys_ready, state, lock_loss_cnt}, {3'b000, 1'b0, 3'd0, 8'd1});
        end
        mmcm_locked = 1'b1;
        wait_state(3'd4, 400, n);
        total++;
        if ({state, lock_loss_cnt} !== {3'd4, 8'd1}) begin bad++; $display("FAIL relock got=%b exp=%b", {state, lock_loss_cnt}, {3'd4, 8'd1}); end
    endtask
    task automatic test_glitch;
        int n;
        pulse_soft();
        total++;
        if ({state, dom_resetn, sys_ready, lock_loss_cnt} !== {3'd0, 3'b000, 1'b0, 8'd1}) begin
            bad++;
            $display("FAIL soft_restart_run got=%b exp=%b", {state, dom_resetn, sys_ready, lock_loss_cnt}, {3'd0, 3'b000, 1'b0, 8'd1});
        end
        wait_state(3'd2, 200, n);
        tick(39);
        mmcm_locked = 1'b0;
        tick(2);
        total++;
        if (state !== 3'd2) begin bad++; $display("FAIL glitch_lag got=%0d exp=2", state); end
        tick();
        total++;
        if ({state, retry_cnt} !== {3'd1, 4'd0}) begin bad++; $display("FAIL glitch_to_wait got=%b exp=%b", {state, retry_cnt}, {3'd1, 4'd0}); end
        tick(2);
        mmcm_locked = 1'b1;
        wait_state(3'd2, 20, n);
        n = 0;
        while (state === 3'd2 && n < 200) begin
            tick();
            n++;
        end
        total++;
        if (n !== 64) begin bad++; $display("FAIL glitch_fresh_stable got=%0d exp=64", n); end
        wait_state(3'd4, 100, n);
        total++;
        if ({state, retry_cnt} !== {3'd4, 4'd0}) begin bad++; $display("FAIL glitch_run got=%b exp=%b", {state, retry_cnt}, {3'd4, 4'd0}); end
    endtask
    task automatic test_soft_vs_loss;
        mmcm_locked = 1'b0;
        tick(2);
        pulse_soft();
        total++;
        if ({state, sys_ready, dom_resetn, lock_loss_cnt} !== {3'd0, 1'b0, 3'b000, 8'd1}) begin
            bad++;
            $display("FAIL soft_wins got=%b exp=%b", {state, sys_ready, dom_resetn, lock_loss_cnt}, {3'd0, 1'b0, 3'b000, 8'd1});
        end
        tick(5);
        total++;
        if ({state, lock_loss_cnt} !== {3'd0, 8'd1}) begin bad++; $display("FAIL soft_wins_hold got=%b exp=%b", {state, lock_loss_cnt}, {3'd0, 8'd1}); end
    endtask
    task automatic test_timeout;
        int n;
        pulse_soft();
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (mmcm_reset === 1'b1 && n < 100) begin
                tick();
                n++;
            end
            total++;
            if (n !== 16) begin bad++; $display("FAIL to_pulse%0d got=%0d exp=16", k, n); end
            n = 0;
            while (mmcm_reset === 1'b0 && n < TO + 50) begin
                tick();
                n++;
            end
            total++;
            if (n !== TO) begin bad++; $display("FAIL to_window%0d got=%0d exp=%0d", k, n, TO); end
            total++;
            if (k < 4) begin
                if ({state, retry_cnt, fail} !== {3'd0, 4'(k + 1), 1'b0}) begin
                    bad++;
                    $display("FAIL to_retry%0d got=%b exp=%b", k, {state, retry_cnt, fail}, {3'd0, 4'(k + 1), 1'b0});
                end
            end else if ({state, fail, mmcm_reset, dom_resetn, sys_ready, retry_cnt} !== {3'd5, 1'b1, 1'b1, 3'b000, 1'b0, 4'd4}) begin
                bad++;
                $display("FAIL to_fail got=%b exp=%b", {state, fail, mmcm_reset, dom_resetn, sys_ready, retry_cnt}, {3'd5, 1'b1, 1'b1, 3'b000, 1'b0, 4'd4});
            end
        end
        tick(20);
        total++;
        if ({state, fail} !== {3'd5, 1'b1}) begin bad++; $display("FAIL fail_sticky got=%b exp=%b", {state, fail}, {3'd5, 1'b1}); end
        pulse_soft();
        total++;
        if ({fail, retry_cnt, state, mmcm_reset, lock_loss_cnt} !== {1'b0, 4'd0, 3'd0, 1'b1, 8'd1}) begin
            bad++;
            $display("FAIL fail_clear got=%b exp=%b", {fail, retry_cnt, state, mmcm_reset, lock_loss_cnt}, {1'b0, 4'd0, 3'd0, 1'b1, 8'd1});
        end
    endtask
    task automatic test_async_reset;
        int n;
        mmcm_locked = 1'b1;
        wait_state(3'd3, 400, n);
        tick(4);
        total++;
        if (dom_resetn !== 3'b001) begin bad++; $display("FAIL pre_reset_release got=%b exp=001", dom_resetn); end
        #3 reset = 1'b1;
        #1;
        total++;
        if ({mmcm_reset, dom_resetn, sys_ready, fail, retry_cnt, lock_loss_cnt, state} !== {1'b1, 3'b000, 1'b0, 1'b0, 4'd0, 8'd0, 3'd0}) begin
            bad++;
            $display("FAIL async_reset got=%b exp=%b", {mmcm_reset, dom_resetn, sys_ready, fail, retry_cnt, lock_loss_cnt, state}, {1'b1, 3'b000, 1'b0, 1'b0, 4'd0, 8'd0, 3'd0});
        end
        tick();
        reset = 1'b0;
    endtask
    task automatic test_saturation;
        int n;
        int exp;
        for (int k = 0; k < 300; k++) begin
            wait_state(3'd4, 400, n);
            mmcm_locked = 1'b0;
            tick(3);
            mmcm_locked = 1'b1;
            exp = (k + 1 > 255) ? 255 : k + 1;
            total++;
            if (lock_loss_cnt !== 8'(exp)) begin bad++; $display("FAIL loss_count%0d got=%0d exp=%0d", k, lock_loss_cnt, exp); end
        end
    endtask
    initial begin
        test_reset();
        test_normal_lock();
        test_lock_loss_run();
        test_glitch();
        test_soft_vs_loss();
        test_timeout();
        test_async_reset();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
